// File: rtl/alu_issue_stage_if.sv
`default_nettype none
// ----------------------------------------------------------------------------
// alu_issue_stage_if : operand/select handshake bundle around the ALU issue stage
// Revision 1.0
// ----------------------------------------------------------------------------
interface alu_issue_stage_if #(
    parameter int XLEN = 32
);
    // Upstream side: decoded instruction plus register-file operands
    logic            in_valid;
    logic            in_ready;
    logic [31:0]     instr;
    logic [XLEN-1:0] rs1_val;
    logic [XLEN-1:0] rs2_val;

    // Downstream side: registered ALU operands and select
    logic            out_valid;
    logic            out_ready;
    logic [XLEN-1:0] inp_A;
    logic [XLEN-1:0] inp_B;
    logic [3:0]      sel;
    logic [4:0]      rd;
    logic            illegal;

    modport master (
        output in_valid, instr, rs1_val, rs2_val, out_ready,
        input  in_ready, out_valid, inp_A, inp_B, sel, rd, illegal
    );

    modport slave (
        input  in_valid, instr, rs1_val, rs2_val, out_ready,
        output in_ready, out_valid, inp_A, inp_B, sel, rd, illegal
    );
endinterface
`default_nettype wire

// File: rtl/alu_issue_stage.sv
`default_nettype none
// ----------------------------------------------------------------------------
// alu_issue_stage : RV32I R/I-type ALU decode feeding a 2-entry skid buffer
// Revision 1.0
// ----------------------------------------------------------------------------
module alu_issue_stage #(
    parameter int         XLEN        = 32,
    parameter logic [3:0] ILLEGAL_SEL = 4'b1111
) (
    input  logic             clk,
    input  logic             rst_n,
    alu_issue_stage_if.slave bus
);
    localparam logic [6:0] C_OP_R    = 7'b0110011;
    localparam logic [6:0] C_OP_I    = 7'b0010011;
    localparam logic [6:0] C_F7_BASE = 7'b0000000;
    localparam logic [6:0] C_F7_ALT  = 7'b0100000;
    localparam logic [3:0] C_SEL_ADD = 4'b0000;
    localparam logic [3:0] C_SEL_SUB = 4'b0001;
    localparam logic [3:0] C_SEL_AND = 4'b0010;
    localparam logic [3:0] C_SEL_OR  = 4'b0011;
    localparam logic [3:0] C_SEL_SLT = 4'b0101;

    typedef struct packed {
        logic [XLEN-1:0] a;
        logic [XLEN-1:0] b;
        logic [3:0]      sel;
        logic [4:0]      rd;
        logic            illegal;
    } entry_t;

    typedef enum logic [1:0] {
        S_EMPTY = 2'd0,
        S_ONE   = 2'd1,
        S_FULL  = 2'd2
    } occ_e;

    // ------------------------------------------------------------------
    // Decode
    // ------------------------------------------------------------------
    logic [6:0]      w_opcode;
    logic [2:0]      w_funct3;
    logic [6:0]      w_funct7;
    logic [XLEN-1:0] w_imm;
    logic [3:0]      w_f3_sel;
    logic            w_f3_ok;
    entry_t          w_dec;

    always_comb begin
        w_opcode = bus.instr[6:0];
        w_funct3 = bus.instr[14:12];
        w_funct7 = bus.instr[31:25];
        w_imm    = {{(XLEN-12){bus.instr[31]}}, bus.instr[31:20]};

        // funct3 -> select is shared by the register and immediate forms
        w_f3_sel = ILLEGAL_SEL;
        w_f3_ok  = 1'b0;
        case (w_funct3)
            3'b000:  begin w_f3_sel = C_SEL_ADD; w_f3_ok = 1'b1; end
            3'b111:  begin w_f3_sel = C_SEL_AND; w_f3_ok = 1'b1; end
            3'b110:  begin w_f3_sel = C_SEL_OR;  w_f3_ok = 1'b1; end
            3'b010:  begin w_f3_sel = C_SEL_SLT; w_f3_ok = 1'b1; end
            default: begin w_f3_sel = ILLEGAL_SEL; w_f3_ok = 1'b0; end
        endcase

        w_dec.a       = bus.rs1_val;
        w_dec.b       = bus.rs2_val;
        w_dec.sel     = ILLEGAL_SEL;
        w_dec.rd      = bus.instr[11:7];
        w_dec.illegal = 1'b1;

        if (w_opcode == C_OP_R) begin
            if (w_f3_ok && (w_funct7 == C_F7_BASE)) begin
                w_dec.sel     = w_f3_sel;
                w_dec.illegal = 1'b0;
            end else if ((w_funct3 == 3'b000) && (w_funct7 == C_F7_ALT)) begin
                w_dec.sel     = C_SEL_SUB;
                w_dec.illegal = 1'b0;
            end
        end else if (w_opcode == C_OP_I) begin
            // Illegal immediate encodings keep rs2_val as operand B
            if (w_f3_ok) begin
                w_dec.b       = w_imm;
                w_dec.sel     = w_f3_sel;
                w_dec.illegal = 1'b0;
            end
        end
    end

    // rs1 field is not needed: operand A arrives already read
    logic w_unused_rs1_field;
    assign w_unused_rs1_field = ^bus.instr[19:15];

    // ------------------------------------------------------------------
    // Occupancy FSM
    // ------------------------------------------------------------------
    occ_e   occ_q, occ_d;
    entry_t head_q, head_d;
    entry_t tail_q, tail_d;
    logic   w_push;
    logic   w_pop;

    // in_ready depends only on registered occupancy, never on out_ready
    assign bus.in_ready  = (occ_q != S_FULL);
    assign bus.out_valid = (occ_q != S_EMPTY);
    assign w_push        = bus.in_valid & bus.in_ready;
    assign w_pop         = bus.out_valid & bus.out_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            occ_q  <= S_EMPTY;
            head_q <= '0;
            tail_q <= '0;
        end else begin
            occ_q  <= occ_d;
            head_q <= head_d;
            tail_q <= tail_d;
        end
    end

    always_comb begin
        occ_d  = occ_q;
        head_d = head_q;
        tail_d = tail_q;
        case (occ_q)
            S_EMPTY: begin
                if (w_push) begin
                    occ_d  = S_ONE;
                    head_d = w_dec;
                end
            end
            S_ONE: begin
                if (w_push && w_pop) begin
                    head_d = w_dec;
                end else if (w_push) begin
                    occ_d  = S_FULL;
                    tail_d = w_dec;
                end else if (w_pop) begin
                    occ_d  = S_EMPTY;
                end
            end
            S_FULL: begin
                if (w_pop) begin
                    occ_d  = S_ONE;
                    head_d = tail_q;
                end
            end
            default: begin
                occ_d = S_EMPTY;
            end
        endcase
    end

    assign bus.inp_A   = head_q.a;
    assign bus.inp_B   = head_q.b;
    assign bus.sel     = head_q.sel;
    assign bus.rd      = head_q.rd;
    assign bus.illegal = head_q.illegal;

endmodule
`default_nettype wire

// File: tb/tb_alu_issue_stage.sv
`default_nettype none
// ----------------------------------------------------------------------------
// tb_alu_issue_stage : directed and random checks of the ALU issue stage
// Revision 1.0
// ----------------------------------------------------------------------------
module tb_alu_issue_stage;
    logic clk;
    logic rst_n;
    int   n_chk;
    int   n_err;
    bit   stream_done;

    alu_issue_stage_if #(.XLEN(32)) bus ();

    alu_issue_stage #(
        .XLEN        (32),
        .ILLEGAL_SEL (4'b1111)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
        logic [3:0]  sel;
        logic [4:0]  rd;
        logic        ill;
    } exp_t;

    exp_t sb[$];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    // Reference decode written from the instruction-set rules
    function automatic exp_t golden(input logic [31:0] ins, input logic [31:0] r1, input logic [31:0] r2);
        exp_t e;
        int   op;
        int   f3;
        int   f7;
        int   code;
        int   simm;
        bit   imm_form;
        op = int'(ins[6:0]);
        f3 = int'(ins[14:12]);
        f7 = int'(ins[31:25]);
        code = -1;
        imm_form = 1'b0;
        e.a  = r1;
        e.b  = r2;
        e.rd = ins[11:7];
        if (op == 'h33) begin
            if (f7 == 0) begin
                case (f3)
                    0: code = 0;
                    7: code = 2;
                    6: code = 3;
                    2: code = 5;
                    default: code = -1;
                endcase
            end else if (f7 == 'h20 && f3 == 0) begin
                code = 1;
            end
        end else if (op == 'h13) begin
            imm_form = 1'b1;
            case (f3)
                0: code = 0;
                7: code = 2;
                6: code = 3;
                2: code = 5;
                default: code = -1;
            endcase
        end
        if (code < 0) begin
            e.sel = 4'hF;
            e.ill = 1'b1;
        end else begin
            e.sel = code[3:0];
            e.ill = 1'b0;
            if (imm_form) begin
                simm = int'(ins[31:20]);
                if (simm >= 2048) simm = simm - 4096;
                e.b = 32'(simm);
            end
        end
        return e;
    endfunction

    function automatic logic [31:0] rand_legal();
        logic [31:0] w;
        int          k;
        w = $urandom;
        k = int'($urandom_range(0, 8));
        case (k)
            0: w = {7'h00, w[24:15], 3'b000, w[11:7], 7'b0110011};
            1: w = {7'h20, w[24:15], 3'b000, w[11:7], 7'b0110011};
            2: w = {7'h00, w[24:15], 3'b111, w[11:7], 7'b0110011};
            3: w = {7'h00, w[24:15], 3'b110, w[11:7], 7'b0110011};
            4: w = {7'h00, w[24:15], 3'b010, w[11:7], 7'b0110011};
            5: w = {w[31:20], w[19:15], 3'b000, w[11:7], 7'b0010011};
            6: w = {w[31:20], w[19:15], 3'b111, w[11:7], 7'b0010011};
            7: w = {w[31:20], w[19:15], 3'b110, w[11:7], 7'b0010011};
            default: w = {w[31:20], w[19:15], 3'b010, w[11:7], 7'b0010011};
        endcase
        return w;
    endfunction

    // Scoreboard: the model queue length is the expected occupancy
    always @(negedge clk) begin
        exp_t e;
        if (!rst_n) begin
            sb.delete();
        end else begin
            check("in_ready", {31'd0, bus.in_ready}, {31'd0, sb.size() < 2});
            check("out_valid", {31'd0, bus.out_valid}, {31'd0, sb.size() > 0});
            if (bus.out_valid && sb.size() > 0) begin
                e = sb[0];
                check("inp_A", bus.inp_A, e.a);
                check("inp_B", bus.inp_B, e.b);
                check("sel", {28'd0, bus.sel}, {28'd0, e.sel});
                check("rd", {27'd0, bus.rd}, {27'd0, e.rd});
                check("illegal", {31'd0, bus.illegal}, {31'd0, e.ill});
                if (bus.out_ready) void'(sb.pop_front());
            end
            if (bus.in_valid && bus.in_ready)
                sb.push_back(golden(bus.instr, bus.rs1_val, bus.rs2_val));
        end
    end

    task automatic send(input logic [31:0] ins, input logic [31:0] r1, input logic [31:0] r2);
        logic acc;
        acc = 1'b0;
        bus.in_valid = 1'b1;
        bus.instr    = ins;
        bus.rs1_val  = r1;
        bus.rs2_val  = r2;
        for (int t = 0; t < 200 && !acc; t++) begin
            @(negedge clk);
            acc = bus.in_ready;
            @(posedge clk);
            #1;
        end
        check("accept_timeout", {31'd0, acc}, 32'd1);
        bus.in_valid = 1'b0;
        bus.instr    = $urandom;
        bus.rs1_val  = $urandom;
        bus.rs2_val  = $urandom;
    endtask

    task automatic drain();
        for (int t = 0; t < 50 && bus.out_valid; t++) begin
            @(posedge clk);
            #1;
        end
        check("drain_out_valid", {31'd0, bus.out_valid}, 32'd0);
        check("drain_sb_empty", sb.size(), 32'd0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        n_chk = 0;
        n_err = 0;
        stream_done  = 1'b0;
        rst_n        = 1'b0;
        bus.in_valid = 1'b0;
        bus.instr    = 32'h0;
        bus.rs1_val  = 32'h0;
        bus.rs2_val  = 32'h0;
        bus.out_ready = 1'b0;

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        check("rst_out_valid", {31'd0, bus.out_valid}, 32'd0);
        check("rst_sel", {28'd0, bus.sel}, 32'd0);
        check("rst_illegal", {31'd0, bus.illegal}, 32'd0);
        check("rst_inp_A", bus.inp_A, 32'd0);
        check("rst_inp_B", bus.inp_B, 32'd0);
        check("rst_rd", {27'd0, bus.rd}, 32'd0);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        check("post_rst_in_ready", {31'd0, bus.in_ready}, 32'd1);

        // sub x3,x1,x2
        bus.out_ready = 1'b1;
        send(32'h402081B3, 32'd10, 32'd3);
        check("sub_valid", {31'd0, bus.out_valid}, 32'd1);
        check("sub_sel", {28'd0, bus.sel}, 32'd1);
        check("sub_A", bus.inp_A, 32'd10);
        check("sub_B", bus.inp_B, 32'd3);
        check("sub_rd", {27'd0, bus.rd}, 32'd3);

        // addi x5,x1,-1
        send(32'hFFF08293, 32'd7, 32'd99);
        check("addi_sel", {28'd0, bus.sel}, 32'd0);
        check("addi_A", bus.inp_A, 32'd7);
        check("addi_B", bus.inp_B, 32'hFFFFFFFF);
        check("addi_rd", {27'd0, bus.rd}, 32'd5);
        check("addi_illegal", {31'd0, bus.illegal}, 32'd0);
        drain();

        // Backpressure: two fill the buffer, the third waits
        bus.out_ready = 1'b0;
        send(32'h002080B3, 32'd1, 32'd11);
        send(32'h40208133, 32'd2, 32'd22);
        check("bp_in_ready_full", {31'd0, bus.in_ready}, 32'd0);
        fork
            send(32'h0020F1B3, 32'd3, 32'd33);
            begin
                repeat (3) @(posedge clk);
                #1;
                check("bp_held_in_ready", {31'd0, bus.in_ready}, 32'd0);
                check("bp_head_rd", {27'd0, bus.rd}, 32'd1);
                bus.out_ready = 1'b1;
            end
        join
        drain();

        // lw x2,0(x1) is not an ALU op
        send(32'h0000A103, 32'h1234, 32'h5678);
        check("ill_sel", {28'd0, bus.sel}, 32'hF);
        check("ill_flag", {31'd0, bus.illegal}, 32'd1);
        check("ill_B", bus.inp_B, 32'h5678);
        check("ill_rd", {27'd0, bus.rd}, 32'd2);
        @(posedge clk);
        #1;
        check("ill_once", {31'd0, bus.out_valid}, 32'd0);

        // Random stream with random downstream stalls
        stream_done = 1'b0;
        fork
            begin
                for (int i = 0; i < 100; i++) begin
                    if ($urandom_range(0, 3) == 0) begin
                        @(posedge clk);
                        #1;
                    end
                    send(rand_legal(), $urandom, $urandom);
                end
                stream_done = 1'b1;
            end
            begin
                while (!stream_done) begin
                    @(posedge clk);
                    #1;
                    bus.out_ready = 1'($urandom_range(0, 1));
                end
            end
        join
        bus.out_ready = 1'b1;
        drain();

        // Reset asserted while the buffer is full
        bus.out_ready = 1'b0;
        send(rand_legal(), $urandom, $urandom);
        send(rand_legal(), $urandom, $urandom);
        #3;
        rst_n = 1'b0;
        #1;
        check("midrst_out_valid", {31'd0, bus.out_valid}, 32'd0);
        check("midrst_sel", {28'd0, bus.sel}, 32'd0);
        check("midrst_illegal", {31'd0, bus.illegal}, 32'd0);
        @(posedge clk);
        @(posedge clk);
        #3;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        check("midrst_in_ready", {31'd0, bus.in_ready}, 32'd1);
        check("midrst_empty", {31'd0, bus.out_valid}, 32'd0);
        bus.out_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1;

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule
`default_nettype wire
